// File: rtl/pad_bridge_pkg.sv
// rtl/pad_bridge_pkg.sv - shared types and helpers for the pad serial bridge
package pad_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        REQ   = 3'd3,
        RDATA = 3'd4
    } state_t;

    // Widest beat the parity helper accepts; narrower beats are zero-extended.
    localparam int PAR_MAX_W = 64;

    function automatic int calc_ab(input int addr_w, input int pad_w);
        return addr_w / pad_w;
    endfunction

    function automatic int calc_db(input int data_w, input int pad_w);
        return data_w / pad_w;
    endfunction

    function automatic int calc_cnt_w(input int ab, input int db);
        int m;
        m = (ab > db) ? ab : db;
        return $clog2(m + 1);
    endfunction

    // Bit that makes the total number of ones in {v, bit} odd.
    function automatic logic odd_par_bit(input logic [PAR_MAX_W-1:0] v);
        return ~(^v);
    endfunction

endpackage

// File: rtl/pad_serial_bridge_if.sv
// rtl/pad_serial_bridge_if.sv - pad and core bus bundle; parity pins under PAD_PARITY_EN
interface pad_serial_bridge_if #(
    parameter int PAD_W  = 8,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              pad_valid;
    logic              pad_wen;
    logic [PAD_W-1:0]  pad_wdata;
    logic [PAD_W-1:0]  pad_rdata;
    logic              pad_rvalid;
    logic              pad_busy;
    logic              pad_ack;
    logic              core_valid;
    logic              core_wen;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_ready;
`ifdef PAD_PARITY_EN
    logic              pad_par_in;
    logic              pad_par_out;
    logic              pad_err;

    modport slave (
        input  pad_valid, pad_wen, pad_wdata, pad_par_in, core_rdata, core_ready,
        output pad_rdata, pad_rvalid, pad_busy, pad_ack, pad_par_out, pad_err,
        output core_valid, core_wen, core_addr, core_wdata
    );
    modport master (
        output pad_valid, pad_wen, pad_wdata, pad_par_in, core_rdata, core_ready,
        input  pad_rdata, pad_rvalid, pad_busy, pad_ack, pad_par_out, pad_err,
        input  core_valid, core_wen, core_addr, core_wdata
    );
`else
    modport slave (
        input  pad_valid, pad_wen, pad_wdata, core_rdata, core_ready,
        output pad_rdata, pad_rvalid, pad_busy, pad_ack,
        output core_valid, core_wen, core_addr, core_wdata
    );
    modport master (
        output pad_valid, pad_wen, pad_wdata, core_rdata, core_ready,
        input  pad_rdata, pad_rvalid, pad_busy, pad_ack,
        input  core_valid, core_wen, core_addr, core_wdata
    );
`endif
endinterface

// File: rtl/pad_beat_shreg.sv
// rtl/pad_beat_shreg.sv - PAD_W-sliced shift register, lowest slice presented first
module pad_beat_shreg #(
    parameter int PAD_W = 8,
    parameter int NB    = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [NB*PAD_W-1:0]   din_i,
    output logic [PAD_W-1:0]      beat_o
);
    logic [NB*PAD_W-1:0] sr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= din_i;
        end else if (shift_i) begin
            sr_q <= sr_q >> PAD_W;
        end
    end

    assign beat_o = sr_q[PAD_W-1:0];
endmodule

// File: rtl/pad_serial_bridge.sv
// rtl/pad_serial_bridge.sv - pad beat to core request bridge; optional parity via PAD_PARITY_EN
module pad_serial_bridge
    import pad_bridge_pkg::*;
#(
    parameter int PAD_W  = 8,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    pad_serial_bridge_if.slave   bus
);
    localparam int AB = calc_ab(ADDR_W, PAD_W);
    localparam int DB = calc_db(DATA_W, PAD_W);
    localparam int CW = calc_cnt_w(AB, DB);
    localparam logic [CW-1:0] AB_LAST = CW'(AB - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);

    if ((ADDR_W % PAD_W) != 0) begin : g_addr_w_check
        $error("ADDR_W must be a multiple of PAD_W");
    end
    if ((DATA_W % PAD_W) != 0) begin : g_data_w_check
        $error("DATA_W must be a multiple of PAD_W");
    end

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              core_valid_q;
    logic              busy_q;
    logic              ack_q;
    logic              rvalid_q;
    logic              beat_ok;
    logic              rd_load;
    logic              rd_shift;
    logic [PAD_W-1:0]  rd_beat;

`ifdef PAD_PARITY_EN
    logic err_q;
    logic accepting;

    assign beat_ok   = ^{bus.pad_wdata, bus.pad_par_in};
    assign accepting = (state_q == IDLE) || (state_q == ADDR) || (state_q == WDATA);

    // Any bad accepted beat sets the error; only a clean first beat clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (bus.pad_valid && accepting && !beat_ok) begin
            err_q <= 1'b1;
        end else if (bus.pad_valid && beat_ok && (state_q == IDLE)) begin
            err_q <= 1'b0;
        end
    end

    assign bus.pad_err     = err_q;
    assign bus.pad_par_out = rvalid_q ? odd_par_bit(PAR_MAX_W'(rd_beat)) : 1'b0;
`else
    assign beat_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            core_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            rvalid_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.pad_valid && beat_ok) begin
                        wen_q              <= bus.pad_wen;
                        addr_q[PAD_W-1:0]  <= bus.pad_wdata;
                        if (AB == 1) begin
                            cnt_q <= '0;
                            if (bus.pad_wen) begin
                                state_q <= WDATA;
                            end else begin
                                state_q      <= REQ;
                                core_valid_q <= 1'b1;
                                busy_q       <= 1'b1;
                            end
                        end else begin
                            cnt_q   <= CW'(1);
                            state_q <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (bus.pad_valid) begin
                        if (!beat_ok) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            addr_q[cnt_q*PAD_W +: PAD_W] <= bus.pad_wdata;
                            if (cnt_q == AB_LAST) begin
                                cnt_q <= '0;
                                if (wen_q) begin
                                    state_q <= WDATA;
                                end else begin
                                    state_q      <= REQ;
                                    core_valid_q <= 1'b1;
                                    busy_q       <= 1'b1;
                                end
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                end
                WDATA: begin
                    if (bus.pad_valid) begin
                        if (!beat_ok) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            data_q[cnt_q*PAD_W +: PAD_W] <= bus.pad_wdata;
                            if (cnt_q == DB_LAST) begin
                                cnt_q        <= '0;
                                state_q      <= REQ;
                                core_valid_q <= 1'b1;
                                busy_q       <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                end
                REQ: begin
                    if (bus.core_ready) begin
                        core_valid_q <= 1'b0;
                        cnt_q        <= '0;
                        if (wen_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q  <= RDATA;
                            rvalid_q <= 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (cnt_q == DB_LAST) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        rvalid_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rd_load  = (state_q == REQ) && bus.core_ready && !wen_q;
    assign rd_shift = (state_q == RDATA);

    pad_beat_shreg #(
        .PAD_W (PAD_W),
        .NB    (DB)
    ) u_rd_shreg (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (rd_load),
        .shift_i (rd_shift),
        .din_i   (bus.core_rdata),
        .beat_o  (rd_beat)
    );

    assign bus.pad_rdata  = rvalid_q ? rd_beat : '0;
    assign bus.pad_rvalid = rvalid_q;
    assign bus.pad_busy   = busy_q;
    assign bus.pad_ack    = ack_q;
    assign bus.core_valid = core_valid_q;
    assign bus.core_wen   = wen_q;
    assign bus.core_addr  = addr_q;
    assign bus.core_wdata = data_q;
endmodule

// File: tb/tb_pad_serial_bridge.sv
// tb/tb_pad_serial_bridge.sv - randomized self-checking bench for pad_serial_bridge
module tb_pad_serial_bridge;
    localparam int PAD_W  = 8;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int AB     = ADDR_W / PAD_W;
    localparam int DB     = DATA_W / PAD_W;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pad_serial_bridge_if #(.PAD_W(PAD_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pad_serial_bridge #(.PAD_W(PAD_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PAD_W-1:0] slice_of(input logic [63:0] v, input int i);
        return PAD_W'(v >> (PAD_W * i));
    endfunction

    task automatic drive_beat(input logic v, input logic wen, input logic [PAD_W-1:0] d, input bit bad_par);
        bus.pad_valid = v;
        bus.pad_wen   = wen;
        bus.pad_wdata = d;
`ifdef PAD_PARITY_EN
        bus.pad_par_in = (~(^d)) ^ bad_par;
`else
        if (bad_par) bus.pad_wdata = d;
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rvalid"}, 64'(bus.pad_rvalid), 64'd0);
        check({tag, "_rdata"},  64'(bus.pad_rdata),  64'd0);
        check({tag, "_busy"},   64'(bus.pad_busy),   64'd0);
        check({tag, "_cvalid"}, 64'(bus.core_valid), 64'd0);
`ifdef PAD_PARITY_EN
        check({tag, "_parout"}, 64'(bus.pad_par_out), 64'd0);
`endif
    endtask

    // One full transaction; the expected request and read beats come from
    // the address/data values by plain LS-first slicing.
    task automatic run_txn(input bit wen, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input int delay, input int stall_at, input int stall_len, input bit drop);
        logic [PAD_W-1:0] beats[$];
        int nb;
        beats = {};
        for (int i = 0; i < AB; i++) beats.push_back(slice_of(64'(addr), i));
        if (wen) for (int i = 0; i < DB; i++) beats.push_back(slice_of(64'(data), i));
        nb = beats.size();
        bus.core_ready = (delay == 0);
        bus.core_rdata = data;
        for (int i = 0; i < nb; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk); #1;
                    drive_beat(1'b0, 1'($urandom_range(0, 1)), PAD_W'($urandom), 1'b0);
                    @(negedge clk);
                    check("stall_cvalid", 64'(bus.core_valid), 64'd0);
                    check("stall_busy", 64'(bus.pad_busy), 64'd0);
                end
            end
            @(posedge clk); #1;
            drive_beat(1'b1, (i == 0) ? wen : 1'($urandom_range(0, 1)), beats[i], 1'b0);
            @(negedge clk);
            check("beat_cvalid", 64'(bus.core_valid), 64'd0);
        end
        @(posedge clk); #1;
        drive_beat(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("req_cvalid", 64'(bus.core_valid), 64'd1);
        check("req_wen", 64'(bus.core_wen), 64'(wen));
        check("req_addr", 64'(bus.core_addr), 64'(addr));
        if (wen) check("req_wdata", 64'(bus.core_wdata), 64'(data));
        check("req_busy", 64'(bus.pad_busy), 64'd1);
        for (int k = 1; k <= delay; k++) begin
            @(posedge clk); #1;
            if (k == delay) bus.core_ready = 1'b1;
            @(negedge clk);
            check("hold_cvalid", 64'(bus.core_valid), 64'd1);
            check("hold_addr", 64'(bus.core_addr), 64'(addr));
            check("hold_busy", 64'(bus.pad_busy), 64'd1);
        end
        @(posedge clk); #1;
        if (delay > 0) bus.core_ready = 1'b0;
        if (wen) begin
            @(negedge clk);
            check("ack_pulse", 64'(bus.pad_ack), 64'd1);
            check_idle("ack");
            @(posedge clk); #1;
            @(negedge clk);
            check("ack_low", 64'(bus.pad_ack), 64'd0);
        end else begin
            for (int i = 0; i < DB; i++) begin
                if (i > 0) begin
                    @(posedge clk); #1;
                end
                if (drop) drive_beat(1'b1, 1'($urandom_range(0, 1)), PAD_W'($urandom), 1'b0);
                @(negedge clk);
                check("rd_rvalid", 64'(bus.pad_rvalid), 64'd1);
                check("rd_beat", 64'(bus.pad_rdata), 64'(slice_of(64'(data), i)));
                check("rd_busy", 64'(bus.pad_busy), 64'd1);
                check("rd_cvalid", 64'(bus.core_valid), 64'd0);
`ifdef PAD_PARITY_EN
                check("rd_parout", 64'(bus.pad_par_out), 64'(~(^slice_of(64'(data), i))));
`endif
            end
            @(posedge clk); #1;
            drive_beat(1'b0, 1'b0, '0, 1'b0);
            @(negedge clk);
            check_idle("rd_end");
            check("rd_end_ack", 64'(bus.pad_ack), 64'd0);
        end
    endtask

    initial begin
        drive_beat(1'b0, 1'b0, '0, 1'b0);
        bus.core_ready = 1'b0;
        bus.core_rdata = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_ack", 64'(bus.pad_ack), 64'd0);
        check("reset_addr", 64'(bus.core_addr), 64'd0);
        check("reset_wdata", 64'(bus.core_wdata), 64'd0);
`ifdef PAD_PARITY_EN
        check("reset_err", 64'(bus.pad_err), 64'd0);
`endif
        resetn = 1'b1;

        run_txn(1'b1, 8'h10, 32'hDEADBEEF, 0, -1, 0, 1'b0);
        run_txn(1'b0, 8'h42, 32'h12345678, 3, -1, 0, 1'b0);
        run_txn(1'b1, 8'h10, 32'hDEADBEEF, 0, 3, 5, 1'b0);
        run_txn(1'b0, 8'h7E, 32'hCAFEF00D, 1, -1, 0, 1'b1);
        run_txn(1'b1, 8'hA5, 32'h0BADC0DE, 2, -1, 0, 1'b0);

        // Reset while the request is outstanding.
        bus.core_ready = 1'b0;
        for (int i = 0; i < 1 + DB; i++) begin
            @(posedge clk); #1;
            drive_beat(1'b1, (i == 0) ? 1'b1 : 1'b0, PAD_W'(8'h30 + i), 1'b0);
        end
        @(posedge clk); #1;
        drive_beat(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("rst_pre_cvalid", 64'(bus.core_valid), 64'd1);
        #1 resetn = 1'b0;
        #1;
        check_idle("rst_async");
        @(negedge clk);
        resetn = 1'b1;
        run_txn(1'b1, 8'h5A, 32'h11223344, 0, -1, 0, 1'b0);

`ifdef PAD_PARITY_EN
        bus.core_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive_beat(1'b1, (i == 0) ? 1'b1 : 1'b0, slice_of(64'hDEADBEEF10, i), i == 3);
        end
        @(posedge clk); #1;
        drive_beat(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("par_cvalid", 64'(bus.core_valid), 64'd0);
            check("par_err", 64'(bus.pad_err), 64'd1);
            @(posedge clk); #1;
        end
        run_txn(1'b0, 8'h21, 32'h89ABCDEF, 0, -1, 0, 1'b0);
        check("par_err_clr", 64'(bus.pad_err), 64'd0);
`endif

        for (int t = 0; t < 24; t++) begin
            bit w;
            int nb;
            w  = 1'($urandom_range(0, 1));
            nb = w ? AB + DB : AB;
            run_txn(w, ADDR_W'($urandom), DATA_W'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, nb), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
